// File: rtl/quad_pkg.sv
// quad_pkg: shared state type, phase encodings and constants for the
// quadrature decoder. Phase is always written as {A,B}.
package quad_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        PH00 = 3'd1,
        PH10 = 3'd2,
        PH11 = 3'd3,
        PH01 = 3'd4
    } state_t;

    localparam logic [1:0] PHASE_00 = 2'b00;
    localparam logic [1:0] PHASE_10 = 2'b10;
    localparam logic [1:0] PHASE_11 = 2'b11;
    localparam logic [1:0] PHASE_01 = 2'b01;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Map a qualified {A,B} phase onto the FSM state that represents it.
    function automatic state_t phase_to_state(input logic [1:0] phase);
        state_t s;
        case (phase)
            PHASE_00: s = PH00;
            PHASE_10: s = PH10;
            PHASE_11: s = PH11;
            default:  s = PH01;
        endcase
        return s;
    endfunction

    // Phase held by a state; INIT has no phase and reads as 00.
    function automatic logic [1:0] state_to_phase(input state_t s);
        logic [1:0] p;
        case (s)
            PH10:    p = PHASE_10;
            PH11:    p = PHASE_11;
            PH01:    p = PHASE_01;
            default: p = PHASE_00;
        endcase
        return p;
    endfunction

    // Successor phase when counting up: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] phase_up(input logic [1:0] phase);
        logic [1:0] p;
        case (phase)
            PHASE_00: p = PHASE_10;
            PHASE_10: p = PHASE_11;
            PHASE_11: p = PHASE_01;
            default:  p = PHASE_00;
        endcase
        return p;
    endfunction

    // Successor phase when counting down (reverse of phase_up).
    function automatic logic [1:0] phase_down(input logic [1:0] phase);
        logic [1:0] p;
        case (phase)
            PHASE_00: p = PHASE_01;
            PHASE_01: p = PHASE_11;
            PHASE_11: p = PHASE_10;
            default:  p = PHASE_00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// quad_filter: per-channel front end. SYNC_STAGES-deep synchronizer for an
// asynchronous pin, optionally followed by a glitch filter that only accepts
// a new level after FILTER_LEN consecutive equal samples.
// Optional feature macro: QUAD_FILTER_EN (filter present when defined).
module quad_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef QUAD_FILTER_EN
   ,parameter int FILTER_LEN  = 3
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
    logic       level_q, level_d;
    logic [3:0] run_q, run_d;

    // Count consecutive samples that disagree with the accepted level; accept
    // the new level on the FILTER_LEN-th one, drop the run on any agreement.
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync_out != level_q) begin
            if (run_q == 4'(FILTER_LEN - 1)) level_d = sync_out;
            else                             run_d   = run_q + 4'd1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            run_q   <= '0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
        end
    end

    assign q_o = level_q;
`else
    assign q_o = sync_out;
`endif

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: turns two asynchronous quadrature channels into step /
// direction pulses for a downstream up/down counter, flags illegal two-bit
// phase jumps and keeps a saturating error count.
// Optional feature macro: QUAD_FILTER_EN adds a glitch filter per channel.
// After reset the FSM stays in INIT until the front end has refilled with
// the live pin levels, so a level present at release never becomes a step.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       clr_err,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [7:0] err_count,
    output state_t     dbg_state_o
);

`ifdef QUAD_FILTER_EN
    localparam int FILT_ON = 1;
`else
    localparam int FILT_ON = 0;
`endif
    // Clocks from reset release until the qualified phase reflects the pins.
    localparam int         FRONT_LAT = SYNC_STAGES + FILT_ON * FILTER_LEN;
    localparam logic [4:0] PRIME_CNT = 5'(FRONT_LAT);

    logic       a_qual, b_qual;
    logic [1:0] phase, cur_phase;

    quad_filter #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef QUAD_FILTER_EN
       ,.FILTER_LEN(FILTER_LEN)
`endif
    ) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_in),
        .q_o   (a_qual)
    );

    quad_filter #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef QUAD_FILTER_EN
       ,.FILTER_LEN(FILTER_LEN)
`endif
    ) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .d_i   (b_in),
        .q_o   (b_qual)
    );

    assign phase = {a_qual, b_qual};

    state_t     state_q, state_d;
    logic [4:0] prime_q, prime_d;
    logic       step_q, step_d;
    logic       up_down_q, up_down_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    assign cur_phase = state_to_phase(state_q);

    // Next state: classify each qualified phase change as up, down or illegal.
    always_comb begin
        state_d   = state_q;
        prime_d   = prime_q;
        step_d    = 1'b0;
        up_down_d = up_down_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            INIT: begin
                if (prime_q == PRIME_CNT) state_d = phase_to_state(phase);
                else                      prime_d = prime_q + 5'd1;
            end
            default: begin
                if (phase != cur_phase) begin
                    state_d = phase_to_state(phase);
                    if (phase == phase_up(cur_phase)) begin
                        step_d    = 1'b1;
                        up_down_d = 1'b1;
                    end else if (phase == phase_down(cur_phase)) begin
                        step_d    = 1'b1;
                        up_down_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
        if (clr_err)                                cnt_d = '0;
        else if (err_d && (cnt_q != ERR_CNT_MAX))   cnt_d = cnt_q + 8'd1;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            prime_q   <= '0;
            step_q    <= 1'b0;
            up_down_q <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prime_q   <= prime_d;
            step_q    <= step_d;
            up_down_q <= up_down_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign step        = step_q;
    assign up_down     = up_down_q;
    assign err         = err_q;
    assign err_count   = cnt_q;
    assign dbg_state_o = state_q;

endmodule
